// File: rtl/addsub_digit_serial_pkg.sv
// rtl/addsub_digit_serial_pkg.sv - shared types and sizing helpers for the digit-serial adder/subtractor
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of digits needed to cover the full operand width
    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; a single-digit datapath still keeps a 1-bit counter
    function automatic int calc_cnt_w(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/addsub_digit_serial_if.sv
// rtl/addsub_digit_serial_if.sv - operand/result handshake bundle for the digit-serial adder/subtractor
interface addsub_digit_serial_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic             SUB;
    logic             CIN;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] O;
    logic             COUT;
    logic             V;

    modport master (
        output in_valid, I0, I1, SUB, CIN, out_ready,
        input  in_ready, out_valid, O, COUT, V
    );

    modport slave (
        input  in_valid, I0, I1, SUB, CIN, out_ready,
        output in_ready, out_valid, O, COUT, V
    );
endinterface

// File: rtl/addsub_digit_serial_digit.sv
// rtl/addsub_digit_serial_digit.sv - combinational DIGIT-bit adder slice with carry into the top bit
module addsub_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);
    logic [DIGIT:0] full;

    assign full    = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign sum     = full[DIGIT-1:0];
    assign cout    = full[DIGIT];
    // Carry into the top bit recovered from the sum bit; xor with cout gives signed overflow
    assign msb_cin = full[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
endmodule

// File: rtl/addsub_digit_serial.sv
// rtl/addsub_digit_serial.sv - digit-serial add/subtract, LSB digit first, valid/ready in and out
module addsub_digit_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    addsub_digit_serial_if.slave  bus
);
    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int CW   = calc_cnt_w(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_width
        $fatal(1, "addsub_digit_serial: WIDTH must be a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    logic             in_ready;
    logic             accept;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_msb_cin;

    // The operand registers shift right each BUSY cycle, so the active digit is always the low one
    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a       (a_q[DIGIT-1:0]),
        .b       (b_q[DIGIT-1:0]),
        .cin     (carry_q),
        .sum     (dig_sum),
        .cout    (dig_cout),
        .msb_cin (dig_msb_cin)
    );

    assign in_ready      = RESETN & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
    assign accept        = bus.in_valid & in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.O         = o_q;
    assign bus.COUT      = cout_q;
    assign bus.V         = v_q;

    // Next-state and datapath: step one digit in BUSY, publish on the last, load on accept
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        o_d     = o_q;
        cout_d  = cout_q;
        v_d     = v_q;

        case (state_q)
            IDLE: ;
            BUSY: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = WIDTH'({dig_sum, res_q} >> DIGIT);
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    o_d     = res_d;
                    cout_d  = dig_cout;
                    v_d     = dig_msb_cin ^ dig_cout;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Subtraction is A + ~B + 1 with the borrow-in folded into the initial carry
        if (accept) begin
            state_d = BUSY;
            cnt_d   = '0;
            a_d     = bus.I0;
            b_d     = bus.SUB ? ~bus.I1 : bus.I1;
            carry_d = bus.CIN ^ bus.SUB;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            o_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            o_q     <= o_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end
endmodule
